// File: rtl/alu_bank_ctrl_if.sv
// CPU-side handshake and replica-bank bus of the redundant ALU bank controller.
// The controller takes the slave view; the CPU/bank side takes the master view.
interface alu_bank_ctrl_if #(
  parameter int NREP = 8
);
  logic                   cpu_req;
  logic [31:0]            cpu_a;
  logic [31:0]            cpu_b;
  logic [2:0]             cpu_alucont;
  logic                   cpu_gnt;
  logic                   cpu_res_valid;
  logic [31:0]            cpu_result;
  logic                   cpu_zero;
  logic [31:0]            bank_a;
  logic [31:0]            bank_b;
  logic [2:0]             bank_alucont;
  logic [NREP*32-1:0]     rep_result;
  logic [NREP-1:0]        rep_zero;
  logic [NREP-1:0]        rep_en;
  logic [3:0]             healthy_cnt;
  logic                   alarm;
  logic                   scrub_busy;

  modport slave (
    input  cpu_req, cpu_a, cpu_b, cpu_alucont, rep_result, rep_zero,
    output cpu_gnt, cpu_res_valid, cpu_result, cpu_zero,
           bank_a, bank_b, bank_alucont, rep_en, healthy_cnt, alarm, scrub_busy
  );

  modport master (
    output cpu_req, cpu_a, cpu_b, cpu_alucont, rep_result, rep_zero,
    input  cpu_gnt, cpu_res_valid, cpu_result, cpu_zero,
           bank_a, bank_b, bank_alucont, rep_en, healthy_cnt, alarm, scrub_busy
  );
endinterface

// File: rtl/alu_bank_ctrl.sv
// Arbitration, operand issue, majority voting and replica retirement for an N-modular-redundant ALU bank.
// Define ALU_SCRUB_EN to build the background scrub engine that exercises the bank while the CPU is idle.
module alu_bank_ctrl #(
  parameter int NREP         = 8,
  parameter int FAULT_THRESH = 4,
  parameter int SCRUB_IDLE   = 16
) (
  input  logic           clk,
  input  logic           reset,
  alu_bank_ctrl_if.slave bank_if
);
  localparam int         DATA_W   = 32;
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_HALT  = 1'b1;
  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_CPU  = 2'd1;
  localparam logic [3:0] THRESH   = 4'(FAULT_THRESH);

  // Strict majority over the enabled replicas; a tie resolves to 0.
  function automatic logic majority(input logic [NREP-1:0] bits, input logic [NREP-1:0] en);
    int ones;
    int total;
    ones  = $countones(bits & en);
    total = $countones(en);
    return (2 * ones) > total;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  logic [0:0]        state;
  logic              gnt;
  logic              alarm_r;
  logic [1:0]        tag_p1;
  logic [DATA_W-1:0] a_p1;
  logic [DATA_W-1:0] b_p1;
  logic [2:0]        alucont_p1;
  logic [NREP-1:0]   rep_en_r;
  logic [NREP-1:0]   en_nxt;
  logic [3:0]        err_cnt [NREP];
  logic [3:0]        cnt_nxt [NREP];
  logic [DATA_W-1:0] vote_res;
  logic              vote_zero;
  logic              halt_now;
  logic              vld_p2;
  logic [DATA_W-1:0] result_p2;
  logic              zero_p2;

  assign gnt = bank_if.cpu_req && (state == ST_RUN);

`ifdef ALU_SCRUB_EN
  localparam logic [1:0]  TAG_SCRUB = 2'd2;
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'hACE1_ACE1;
  localparam logic [7:0]  IDLE_MAX  = 8'(SCRUB_IDLE);

  logic [7:0]        idle_cnt;
  logic [31:0]       lfsr;
  logic [2:0]        seq_idx;
  logic              scrub_ok;
  logic [DATA_W-1:0] scrub_a;
  logic [DATA_W-1:0] scrub_b;
  logic [2:0]        scrub_alucont;

  // Scrub op rotation: add, sub, and, or, slt.
  function automatic logic [2:0] seq_op(input logic [2:0] idx);
    case (idx)
      3'd0:    return 3'b010;
      3'd1:    return 3'b110;
      3'd2:    return 3'b000;
      3'd3:    return 3'b001;
      default: return 3'b111;
    endcase
  endfunction

  assign scrub_ok      = (idle_cnt == IDLE_MAX) && !bank_if.cpu_req && (state == ST_RUN);
  assign scrub_a       = lfsr;
  assign scrub_b       = {lfsr[18:0], lfsr[31:19]};
  assign scrub_alucont = seq_op(seq_idx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
      lfsr     <= LFSR_SEED;
      seq_idx  <= '0;
    end else begin
      if (bank_if.cpu_req) begin
        idle_cnt <= '0;
      end else if (idle_cnt != IDLE_MAX) begin
        idle_cnt <= idle_cnt + 8'd1;
      end
      if (scrub_ok) begin
        lfsr    <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_POLY : 32'h0);
        seq_idx <= (seq_idx == 3'd4) ? 3'd0 : seq_idx + 3'd1;
      end
    end
  end

  assign bank_if.scrub_busy = (tag_p1 == TAG_SCRUB);
`else
  logic unused_scrub_cfg;
  assign unused_scrub_cfg   = (SCRUB_IDLE == 0);
  assign bank_if.scrub_busy = 1'b0;
`endif

  // Vote stage: combinational over the cycle the op sits in the bank.
  always_comb begin
    logic [NREP-1:0] col;
    vote_res = '0;
    for (int b = 0; b < DATA_W; b++) begin
      col = '0;
      for (int i = 0; i < NREP; i++) begin
        col[i] = bank_if.rep_result[DATA_W*i + b];
      end
      vote_res[b] = majority(col, rep_en_r);
    end
    vote_zero = majority(bank_if.rep_zero, rep_en_r);
  end

  always_comb begin
    en_nxt = rep_en_r;
    for (int i = 0; i < NREP; i++) begin
      cnt_nxt[i] = err_cnt[i];
      if (tag_p1 != TAG_NONE && rep_en_r[i] &&
          (bank_if.rep_result[DATA_W*i +: DATA_W] != vote_res || bank_if.rep_zero[i] != vote_zero)) begin
        cnt_nxt[i] = sat_inc(err_cnt[i]);
        if (cnt_nxt[i] >= THRESH) begin
          en_nxt[i] = 1'b0;
        end
      end
    end
    halt_now = ($countones(en_nxt) < 3);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_RUN;
      alarm_r    <= 1'b0;
      rep_en_r   <= '1;
      for (int i = 0; i < NREP; i++) begin
        err_cnt[i] <= '0;
      end
      tag_p1     <= TAG_NONE;
      a_p1       <= '0;
      b_p1       <= '0;
      alucont_p1 <= '0;
      vld_p2     <= 1'b0;
      result_p2  <= '0;
      zero_p2    <= 1'b0;
    end else begin
      // p1 -> p2: retire disagreeing replicas and register the CPU result
      if (tag_p1 != TAG_NONE) begin
        rep_en_r <= en_nxt;
        for (int i = 0; i < NREP; i++) begin
          err_cnt[i] <= cnt_nxt[i];
        end
        if (halt_now) begin
          alarm_r <= 1'b1;
          state   <= ST_HALT;
        end
      end
      vld_p2 <= (tag_p1 == TAG_CPU);
      if (tag_p1 == TAG_CPU) begin
        result_p2 <= vote_res;
        zero_p2   <= vote_zero;
      end

      // issue -> p1: CPU has priority over scrub
      if (gnt) begin
        tag_p1     <= TAG_CPU;
        a_p1       <= bank_if.cpu_a;
        b_p1       <= bank_if.cpu_b;
        alucont_p1 <= bank_if.cpu_alucont;
      end
`ifdef ALU_SCRUB_EN
      else if (scrub_ok) begin
        tag_p1     <= TAG_SCRUB;
        a_p1       <= scrub_a;
        b_p1       <= scrub_b;
        alucont_p1 <= scrub_alucont;
      end
`endif
      else begin
        tag_p1 <= TAG_NONE;
      end
    end
  end

  assign bank_if.cpu_gnt       = gnt;
  assign bank_if.cpu_res_valid = vld_p2;
  assign bank_if.cpu_result    = result_p2;
  assign bank_if.cpu_zero      = zero_p2;
  assign bank_if.bank_a        = a_p1;
  assign bank_if.bank_b        = b_p1;
  assign bank_if.bank_alucont  = alucont_p1;
  assign bank_if.rep_en        = rep_en_r;
  assign bank_if.healthy_cnt   = 4'($countones(rep_en_r));
  assign bank_if.alarm         = alarm_r;
endmodule

// File: tb/tb_alu_bank_ctrl.sv
// Bench for alu_bank_ctrl: behavioural replica ALUs with fault injection, random CPU traffic,
// and a transaction-level model of voting, retirement, halt and (with ALU_SCRUB_EN) scrubbing.
module tb_alu_bank_ctrl;
  localparam int NREP         = 8;
  localparam int FAULT_THRESH = 4;
  localparam int SCRUB_IDLE   = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  alu_bank_ctrl_if #(.NREP(NREP)) bus();

  alu_bank_ctrl #(
    .NREP(NREP), .FAULT_THRESH(FAULT_THRESH), .SCRUB_IDLE(SCRUB_IDLE)
  ) dut (
    .clk(clk), .reset(reset), .bank_if(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] and_m [NREP];
  logic [31:0] xor_m [NREP];
  logic [2:0]  ops [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

  // Reference model state
  logic [NREP-1:0] m_en;
  int              m_err [NREP];
  bit              m_halt, m_alarm;
  int              m_tag;
  logic [31:0]     m_a, m_b;
  logic [2:0]      m_op;
  bit              m_vld;
  logic [31:0]     m_res;
  bit              m_zero;
  int              m_idle;
  logic [31:0]     m_lfsr;
  int              m_sidx;

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    case (op)
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Replica ALUs: each computes from the bank operands, then its fault masks apply.
  always_comb begin
    logic [31:0] v;
    bus.rep_result = '0;
    bus.rep_zero   = '0;
    for (int i = 0; i < NREP; i++) begin
      v = (alu_ref(bus.bank_a, bus.bank_b, bus.bank_alucont) & and_m[i]) ^ xor_m[i];
      bus.rep_result[32*i +: 32] = v;
      bus.rep_zero[i] = (v == 32'd0);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_en = '1;
    for (int i = 0; i < NREP; i++) m_err[i] = 0;
    m_halt = 0; m_alarm = 0; m_tag = 0;
    m_a = '0; m_b = '0; m_op = '0;
    m_vld = 0; m_res = '0; m_zero = 0;
    m_idle = 0; m_lfsr = 32'hACE1_ACE1; m_sidx = 0;
  endtask

  task automatic check_outputs();
    check("gnt", bus.cpu_gnt, bus.cpu_req && !m_halt);
    check("res_valid", bus.cpu_res_valid, m_vld);
    check("result", bus.cpu_result, m_res);
    check("zero", bus.cpu_zero, m_zero);
    check("rep_en", bus.rep_en, m_en);
    check("healthy", bus.healthy_cnt, $countones(m_en));
    check("alarm", bus.alarm, m_alarm);
    check("scrub_busy", bus.scrub_busy, m_tag == 2);
    check("bank_a", bus.bank_a, m_a);
    check("bank_b", bus.bank_b, m_b);
    check("bank_alucont", bus.bank_alucont, m_op);
  endtask

  // Advance the model across one clock edge using this cycle's inputs and fault masks.
  task automatic model_step();
    logic [31:0] g, v;
    logic [31:0] vals [NREP];
    int   ones, zc, alive;
    bit   z, halt_next, scrub_ok;
    halt_next = 0;
    if (m_tag != 0) begin
      g = alu_ref(m_a, m_b, m_op);
      for (int i = 0; i < NREP; i++) vals[i] = (g & and_m[i]) ^ xor_m[i];
      alive = $countones(m_en);
      for (int b = 0; b < 32; b++) begin
        ones = 0;
        for (int i = 0; i < NREP; i++) if (m_en[i] && vals[i][b]) ones++;
        v[b] = (2 * ones > alive);
      end
      zc = 0;
      for (int i = 0; i < NREP; i++) if (m_en[i] && vals[i] == 32'd0) zc++;
      z = (2 * zc > alive);
      for (int i = 0; i < NREP; i++) begin
        if (m_en[i] && (vals[i] != v || (vals[i] == 32'd0) != z)) begin
          if (m_err[i] < 15) m_err[i]++;
          if (m_err[i] >= FAULT_THRESH) m_en[i] = 1'b0;
        end
      end
      if ($countones(m_en) < 3) begin
        m_alarm = 1; halt_next = 1;
      end
      m_vld = (m_tag == 1);
      if (m_tag == 1) begin
        m_res = v; m_zero = z;
      end
    end else begin
      m_vld = 0;
    end
    scrub_ok = 0;
`ifdef ALU_SCRUB_EN
    scrub_ok = (m_idle == SCRUB_IDLE) && !bus.cpu_req && !m_halt;
    if (bus.cpu_req) m_idle = 0;
    else if (m_idle < SCRUB_IDLE) m_idle++;
`endif
    if (bus.cpu_req && !m_halt) begin
      m_tag = 1; m_a = bus.cpu_a; m_b = bus.cpu_b; m_op = bus.cpu_alucont;
    end else if (scrub_ok) begin
      m_tag = 2; m_a = m_lfsr; m_b = (m_lfsr << 13) | (m_lfsr >> 19); m_op = ops[m_sidx];
      m_sidx = (m_sidx + 1) % 5;
      m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 32'h8020_0003) : (m_lfsr >> 1);
    end else begin
      m_tag = 0;
    end
    m_halt = m_halt | halt_next;
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input bit req);
    bus.cpu_req     = req;
    bus.cpu_a       = $urandom;
    bus.cpu_b       = ($urandom_range(0, 4) == 0) ? bus.cpu_a : $urandom;
    bus.cpu_alucont = ops[$urandom_range(0, 4)];
  endtask

  task automatic do_reset();
    bus.cpu_req = 1'b0;
    for (int i = 0; i < NREP; i++) begin
      and_m[i] = 32'hFFFF_FFFF; xor_m[i] = 32'h0;
    end
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cpu_req = 1'b0; bus.cpu_a = '0; bus.cpu_b = '0; bus.cpu_alucont = '0;
    do_reset();

    // Directed add: grant in cycle 0, result in cycle 2
    bus.cpu_req = 1'b1; bus.cpu_a = 32'd5; bus.cpu_b = 32'd7; bus.cpu_alucont = 3'b010;
    cycle();
    bus.cpu_req = 1'b0;
    cycle();
    check("add_vld", bus.cpu_res_valid, 1);
    check("add_res", bus.cpu_result, 32'd12);
    check("add_zero", bus.cpu_zero, 0);
    check("add_en", bus.rep_en, 8'hFF);
    cycle();

    // Replica 3 stuck at 0xDEADBEEF under random CPU traffic
    do_reset();
    and_m[3] = 32'h0; xor_m[3] = 32'hDEAD_BEEF;
    for (int k = 0; k < 300 && m_en[3]; k++) begin
      set_op($urandom_range(0, 3) != 0);
      cycle();
    end
    check("rep3_en", bus.rep_en, 8'hF7);
    check("rep3_healthy", bus.healthy_cnt, 7);
    and_m[3] = 32'hFFFF_FFFF; xor_m[3] = 32'h0;
    for (int k = 0; k < 200; k++) begin
      set_op($urandom_range(0, 1) != 0);
      cycle();
    end

    // Retire replicas 0..5 one at a time until the bank halts
    do_reset();
    for (int r = 0; r < 6; r++) begin
      xor_m[r] = 32'h0001_0000 << r;
      for (int k = 0; k < 20 && m_en[r]; k++) begin
        set_op(1'b1);
        cycle();
      end
      xor_m[r] = 32'h0;
      if (r == 4) begin
        check("five_healthy", bus.healthy_cnt, 3);
        check("five_alarm", bus.alarm, 0);
      end
    end
    check("halt_alarm", bus.alarm, 1);
    check("halt_healthy", bus.healthy_cnt, 2);
    for (int k = 0; k < 5; k++) begin
      set_op(1'b1);
      check("halt_gnt", bus.cpu_gnt, 0);
      cycle();
    end

`ifdef ALU_SCRUB_EN
    // Scrub start after SCRUB_IDLE idle cycles, then replica 6 stuck-at-0 on bit 31
    do_reset();
    for (int k = 0; k < 17; k++) cycle();
    check("scrub_busy1", bus.scrub_busy, 1);
    check("scrub_a0", bus.bank_a, 32'hACE1_ACE1);
    check("scrub_op0", bus.bank_alucont, 3'b010);
    check("scrub_novld", bus.cpu_res_valid, 0);
    and_m[6] = 32'h7FFF_FFFF;
    for (int k = 0; k < 2000 && m_en[6]; k++) begin
      set_op($urandom_range(0, 19) == 0);
      cycle();
    end
    check("rep6_en", bus.rep_en, 8'hBF);
    and_m[6] = 32'hFFFF_FFFF;
    for (int k = 0; k < 100; k++) begin
      set_op($urandom_range(0, 9) == 0);
      cycle();
    end
`endif

    // Reset one cycle after a grant: the in-flight op never reports
    do_reset();
    set_op(1'b1);
    cycle();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      check("rst_novld", bus.cpu_res_valid, 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_bank_ctrl.md
# alu_bank_ctrl

Controller for the N-modular-redundant ALU bank. It arbitrates the bank between the CPU datapath and a background scrub engine, and registers operands into the replicas. It votes the returned replica results over the replicas still in service and retires replicas that repeatedly disagree with the vote. It also raises a sticky alarm when too few replicas remain to vote safely.

## Interface
- NREP, 8, number of ALU replicas in the bank (3..15)
- FAULT_THRESH, 4, disagreements after which a replica is retired (1..15)
- SCRUB_IDLE, 16, consecutive idle CPU cycles before scrubbing starts (1..255)

- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- cpu_req  in  1  CPU presents an ALU operation this cycle
- cpu_a, cpu_b  in  32  CPU operands
- cpu_alucont  in  3  CPU ALU control
- cpu_gnt  out  1  operation accepted this cycle (combinational)
- cpu_res_valid  out  1  voted result for a CPU operation is valid
- cpu_result  out  32  voted result
- cpu_zero  out  1  voted zero flag
- bank_a, bank_b  out  32  registered operands to all replicas
- bank_alucont  out  3  registered ALU control to all replicas
- rep_result  in  NREP*32  replica results, replica i at [32i+31:32i]
- rep_zero  in  NREP  replica zero flags
- rep_en  out  NREP  replica in-service mask
- healthy_cnt  out  4  popcount of rep_en
- alarm  out  1  sticky: fewer than 3 replicas in service
- scrub_busy  out  1  scrub operation in flight in the bank

## Operation
- FSM states:
  - RUN (reset state)
  - HALT: entered when healthy_cnt < 3; exited only by reset.
- cpu_gnt = cpu_req && state==RUN. The CPU always has priority over scrub.
- Issue stage, at the edge ending cycle N:
  - On grant, the bank_* registers load the CPU operands and tag=CPU.
  - Otherwise, if a scrub issue is permitted, they load the scrub vector and tag=SCRUB.
  - Otherwise the tag becomes NONE and bank_* hold their values.
- Vote stage, combinational over cycle N+1:
  - For each bit, the voted value is 1 iff more than half of the enabled replicas output 1; ties vote 0.
  - cpu_zero is voted the same way.
  - Disabled replicas are ignored.
- Disagreement, evaluated at the edge ending cycle N+1 for tag≠NONE:
  - An enabled replica disagrees if its result ≠ voted result or its zero ≠ voted zero.
  - The replica's 4-bit error counter then increments, saturating.
  - When the counter reaches FAULT_THRESH, the rep_en bit clears. This is sticky until reset.
  - Several replicas may retire on the same edge.
  - Counters of disabled replicas freeze.
- Result: at that same edge, cpu_res_valid, cpu_result and cpu_zero register the vote iff tag==CPU. Otherwise cpu_res_valid=0 and the data hold.
- Retirement driving healthy_cnt below 3:
  - alarm=1 and state moves to HALT on the same edge.
  - The op being voted still completes and is reported, but no further grants or scrubs occur.

## Timing
- Reset values:
  - rep_en all ones, healthy_cnt=NREP, error counters 0.
  - alarm=0, state RUN, tag NONE.
  - bank_a=bank_b=0, bank_alucont=0.
  - cpu_res_valid=0, cpu_result=0, cpu_zero=0, scrub_busy=0.
  - idle counter 0, LFSRs at seeds.
- Latency: cpu_req granted in cycle N gives cpu_res_valid in cycle N+2.
- Throughput: one op per cycle with back-to-back grants.
- Reset mid-operation: the in-flight op is discarded, and no cpu_res_valid follows reset.
- healthy_cnt and alarm update on the edge that retires a replica.

## Configuration
- ALU_SCRUB_EN defined — scrub engine:
  - Idle counter: increments each cycle cpu_req=0 (saturating at SCRUB_IDLE) and clears when cpu_req=1.
  - Scrub issue is permitted when the counter equals SCRUB_IDLE, cpu_req=0 and state==RUN.
  - Operand a comes from a 32-bit Galois LFSR, polynomial 0x80200003, seed 0xACE1ACE1.
  - Operand b is that LFSR's value rotated left 13.
  - alucont steps through 010, 110, 000, 001, 111, advancing only on issue.
  - scrub_busy=1 in the cycle a scrub op sits in the bank.
  - A cpu_req arriving while scrubbing is granted the same cycle. The scrub op already in the bank completes its compare normally.
- ALU_SCRUB_EN undefined: no scrub logic; tag is only CPU or NONE; scrub_busy tied 0. Disagreements are detected only on CPU traffic.

## Test plan
- CPU add, a=5 and b=7 (alucont 010) in cycle 0 -> cpu_res_valid=1 in cycle 2, cpu_result=12, cpu_zero=0; rep_en=0xFF.
- Replica 3 forced to 0xDEADBEEF on 4 CPU ops -> rep_en=0xF7 after the 4th vote edge, healthy_cnt=7; cpu_result correct throughout.
- Replicas 0–5 forced wrong one at a time to FAULT_THRESH -> healthy_cnt 3 after the 5th retirement; on the 6th, alarm=1, healthy_cnt=2, cpu_gnt=0 on later cpu_req.
- With ALU_SCRUB_EN, cpu_req low 16 cycles -> scrub_busy=1 from cycle 17, first scrub a=0xACE1ACE1 alucont 010, cpu_res_valid stays 0.
- With ALU_SCRUB_EN, replica 6 stuck-at-0 bit 31 during scrub -> replica 6 retired after 4 disagreeing scrub ops; a cpu_req mid-scrub is granted the same cycle with a valid result 2 cycles later.
- Reset asserted one cycle after a grant -> cpu_res_valid never rises; all outputs at reset values.
